// File: rtl/pe_mul_pipe.sv
// Broadcast-weight multiplier array: one weight times DATA_COPIES activation lanes
// per beat, per-beat signedness, PIPE_STAGES-deep valid/ready pipeline with beat counter.
module pe_mul_pipe #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DATA_COPIES = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [DATA_WIDTH-1:0]                i_wdata,
  input  logic [DATA_COPIES*DATA_WIDTH-1:0]    i_mdata,
  input  logic                                 i_w_signed,
  input  logic                                 i_m_signed,
  input  logic                                 i_last,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [DATA_COPIES*2*DATA_WIDTH-1:0]  o_mul_result,
  output logic                                 o_last,
  input  logic                                 i_clr_cnt,
  output logic [CNT_WIDTH-1:0]                 o_beat_cnt
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned N  = DATA_COPIES;
  localparam int unsigned S  = PIPE_STAGES;

  logic [S-1:0]        v_q, v_d;
  logic [S-1:0]        last_q, last_d;
  logic [N*PW-1:0]     data_q [S];
  logic [N*PW-1:0]     data_d [S];
  logic [S-1:0]        adv;
  logic [N*PW-1:0]     prod;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Both operands widened to W+1 bits so every sign combination is exact in 2W bits.
  function automatic logic [PW-1:0] lane_mul(
    input logic [W-1:0] w,
    input logic [W-1:0] m,
    input logic         ws,
    input logic         ms
  );
    logic signed [W:0]     a;
    logic signed [W:0]     b;
    logic signed [2*W+1:0] p;
    a = {ws & w[W-1], w};
    b = {ms & m[W-1], m};
    p = (2*W+2)'(a) * (2*W+2)'(b);
    return p[PW-1:0];
  endfunction

  always_comb begin
    prod = '0;
    for (int unsigned k = 0; k < N; k++) begin
      prod[k*PW +: PW] = lane_mul(i_wdata, i_mdata[k*W +: W], i_w_signed, i_m_signed);
    end
  end

  // Flattened form of adv[s] = !v[s] || adv[s+1]: a stage moves if any stage at or
  // downstream of it is empty, or the consumer is taking the output.
  always_comb begin
    adv = '0;
    for (int unsigned s = 0; s < S; s++) begin
      adv[s] = i_ready;
      for (int unsigned t = s; t < S; t++) begin
        if (!v_q[t]) begin
          adv[s] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    v_d    = v_q;
    last_d = last_q;
    data_d = data_q;
    if (adv[0]) begin
      v_d[0]    = i_valid;
      data_d[0] = prod;
      last_d[0] = i_last;
    end
    for (int unsigned s = 1; s < S; s++) begin
      if (adv[s]) begin
        v_d[s]    = v_q[s-1];
        data_d[s] = data_q[s-1];
        last_d[s] = last_q[s-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr_cnt) begin
      cnt_d = '0;
    end else if (v_q[S-1] && i_ready) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v_q    <= '0;
      last_q <= '0;
      cnt_q  <= '0;
      for (int unsigned s = 0; s < S; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      v_q    <= v_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      for (int unsigned s = 0; s < S; s++) begin
        data_q[s] <= data_d[s];
      end
    end
  end

  assign o_ready      = adv[0];
  assign o_valid      = v_q[S-1];
  assign o_mul_result = data_q[S-1];
  assign o_last       = last_q[S-1];
  assign o_beat_cnt   = cnt_q;

endmodule
